// File: rtl/pam4_dfe_slicer.sv
// PAM-4 decision-feedback equalizer and slicer with sign-sign LMS tap adaptation.
// Each feedback tap lives in its own pam4_dfe_tap instance; the top sums their products.

module pam4_dfe_tap #(
  parameter int TAP_WIDTH = 8,
  parameter int MU_STEP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd,
  input  logic                 e_nz,
  input  logic                 e_neg,
  input  logic [2:0]           d,
  output logic [TAP_WIDTH-1:0] h,
  output logic [TAP_WIDTH+2:0] prod
);
  localparam int TW = TAP_WIDTH;
  localparam logic signed [TW+1:0] MU   = (TW+2)'(MU_STEP);
  localparam logic signed [TW+1:0] HMAX = (TW+2)'(2**(TW-1)-1);

  logic signed [TW+1:0] hx, hn;
  logic                 grow;

  // Two guard bits so the step can overshoot before the symmetric clamp.
  always_comb begin
    hx   = {{2{h[TW-1]}}, h};
    grow = (e_neg == d[2]);
    hn   = grow ? hx + MU : hx - MU;
    if (hn > HMAX)       hn = HMAX;
    else if (hn < -HMAX) hn = -HMAX;
  end

  assign prod = $signed({{3{h[TW-1]}}, h}) * $signed({{TW{d[2]}}, d});

  always_ff @(posedge clk) begin
    if (rst)                                   h <= '0;
    else if (upd && e_nz && (d != 3'b000))     h <= hn[TW-1:0];
  end
endmodule

module pam4_dfe_slicer #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int NUM_TAPS          = 2,
  parameter int TAP_WIDTH         = 8,
  parameter int MU_STEP           = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SIGNAL_RESOLUTION-1:0]    signal_in,
  input  logic                            signal_in_valid,
  input  logic                            adapt_en,
  output logic [1:0]                      symbol_out,
  output logic                            symbol_out_valid,
  output logic [SIGNAL_RESOLUTION-1:0]    equalized_out,
  output logic [SIGNAL_RESOLUTION:0]      error_out,
  output logic [NUM_TAPS*TAP_WIDTH-1:0]   taps_out
);
  localparam int R    = SIGNAL_RESOLUTION;
  localparam int S    = SYMBOL_SEPERATION;
  localparam int TW   = TAP_WIDTH;
  localparam int MID  = 1 << (R-1);
  localparam int FW   = TW + 3 + $clog2(NUM_TAPS) + 1;
  localparam int YW   = ((R+1 > FW) ? R+1 : FW) + 1;

  localparam logic signed [R:0] L0 = (R+1)'(MID - (3*S)/2);
  localparam logic signed [R:0] L1 = (R+1)'(MID - S/2);
  localparam logic signed [R:0] L2 = (R+1)'(MID + S/2);
  localparam logic signed [R:0] L3 = (R+1)'(MID + (3*S)/2);
  localparam logic [R-1:0]      T1 = R'(MID - S);
  localparam logic [R-1:0]      T2 = R'(MID);
  localparam logic [R-1:0]      T3 = R'(MID + S);
  localparam logic signed [YW-1:0] YMAX = YW'((1 << R) - 1);

  // hist[0] is d_{n-1}; 3'b000 marks an empty slot.
  logic [NUM_TAPS-1:0][2:0]    hist;
  logic [NUM_TAPS-1:0][TW-1:0] taps;
  logic [NUM_TAPS-1:0][TW+2:0] prods;
  logic [1:0]                  vld_pipe;

  logic signed [FW-1:0] fsum;
  logic signed [YW-1:0] y_raw;
  logic [R-1:0]         y;
  logic [1:0]           lvl, sym;
  logic [2:0]           dcur;
  logic signed [R:0]    lref, e;
  logic                 upd;

  assign vld_pipe[0] = signal_in_valid;
  assign upd         = signal_in_valid & adapt_en;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    pam4_dfe_tap #(.TAP_WIDTH(TW), .MU_STEP(MU_STEP)) u_tap (
      .clk   (clk),
      .rst   (rst),
      .upd   (upd),
      .e_nz  (e != '0),
      .e_neg (e[R]),
      .d     (hist[k]),
      .h     (taps[k]),
      .prod  (prods[k])
    );
  end

  always_comb begin
    fsum = '0;
    for (int k = 0; k < NUM_TAPS; k++) fsum = fsum + FW'($signed(prods[k]));
    y_raw = YW'($signed({1'b0, signal_in})) - YW'(fsum);
    if (y_raw[YW-1])      y = '0;
    else if (y_raw > YMAX) y = '1;
    else                  y = y_raw[R-1:0];
  end

  // Ties resolve to the upper level.
  always_comb begin
    lvl  = 2'd0;
    sym  = 2'b00;
    dcur = 3'b101;
    lref = L0;
    if (y >= T3)      lvl = 2'd3;
    else if (y >= T2) lvl = 2'd2;
    else if (y >= T1) lvl = 2'd1;
    case (lvl)
      2'd0: begin sym = 2'b00; dcur = 3'b101; lref = L0; end
      2'd1: begin sym = 2'b01; dcur = 3'b111; lref = L1; end
      2'd2: begin sym = 2'b11; dcur = 3'b001; lref = L2; end
      default: begin sym = 2'b10; dcur = 3'b011; lref = L3; end
    endcase
    e = $signed({1'b0, y}) - lref;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1]   <= 1'b0;
      symbol_out    <= '0;
      equalized_out <= '0;
      error_out     <= '0;
      hist          <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (signal_in_valid) begin
        symbol_out    <= sym;
        equalized_out <= y;
        error_out     <= e;
        for (int k = NUM_TAPS-1; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= dcur;
      end
    end
  end

  assign symbol_out_valid = vld_pipe[1];
  assign taps_out         = taps;
endmodule

// File: tb/tb_pam4_dfe_slicer.sv
// Directed-vector and reference-model bench for pam4_dfe_slicer.
// A second instance with 4-bit taps exercises tap saturation.

module tb_pam4_dfe_slicer;
  localparam int NSYM = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  signal_in;
  logic        signal_in_valid, adapt_en;
  logic [1:0]  symbol_out;
  logic        symbol_out_valid;
  logic [7:0]  equalized_out;
  logic [8:0]  error_out;
  logic [15:0] taps_out;

  logic [7:0]  s_in;
  logic        s_vld, s_aen;
  logic [1:0]  s_sym;
  logic        s_ovld;
  logic [7:0]  s_eq;
  logic [8:0]  s_err;
  logic [7:0]  s_taps;

  always #5 clk = ~clk;

  pam4_dfe_slicer dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .signal_in_valid(signal_in_valid),
    .adapt_en(adapt_en), .symbol_out(symbol_out), .symbol_out_valid(symbol_out_valid),
    .equalized_out(equalized_out), .error_out(error_out), .taps_out(taps_out));

  pam4_dfe_slicer #(.TAP_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .signal_in(s_in), .signal_in_valid(s_vld),
    .adapt_en(s_aen), .symbol_out(s_sym), .symbol_out_valid(s_ovld),
    .equalized_out(s_eq), .error_out(s_err), .taps_out(s_taps));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the equalizer, built from the level/threshold definitions.
  int LV[4] = '{44, 100, 156, 212};
  int DV[4] = '{-3, -1, 1, 3};
  int mh[2], md[2];
  int ex_sym, ex_y, ex_e;

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  function automatic int gray(input int l);
    return l ^ (l >> 1);
  endfunction

  task automatic model_reset();
    mh = '{0, 0}; md = '{0, 0};
    ex_sym = 0; ex_y = 0; ex_e = 0;
  endtask

  task automatic model_step(input int x, input bit a);
    int f, y, l, e;
    f = mh[0]*md[0] + mh[1]*md[1];
    y = x - f;
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    l = (y >= 184) ? 3 : (y >= 128) ? 2 : (y >= 72) ? 1 : 0;
    e = y - LV[l];
    if (a)
      for (int k = 0; k < 2; k++) begin
        mh[k] += sgn(e) * sgn(md[k]);
        if (mh[k] > 127) mh[k] = 127;
        if (mh[k] < -127) mh[k] = -127;
      end
    md[1] = md[0]; md[0] = DV[l];
    ex_sym = gray(l); ex_y = y; ex_e = e;
  endtask

  function automatic int tap(input int k);
    logic [7:0] t;
    t = taps_out[k*8 +: 8];
    return int'($signed(t));
  endfunction

  task automatic cyc(input int x, input bit v, input bit a);
    signal_in = 8'(x); signal_in_valid = v; adapt_en = a;
    @(negedge clk);
  endtask

  task automatic sample_chk(input string tag, input int x, input bit a);
    cyc(x, 1'b1, a);
    model_step(x, a);
    chk({tag, "_sym"}, int'(symbol_out), ex_sym);
    chk({tag, "_vld"}, int'(symbol_out_valid), 1);
    chk({tag, "_eq"},  int'(equalized_out), ex_y);
    chk({tag, "_err"}, int'($signed(error_out)), ex_e);
    chk({tag, "_h1"},  tap(0), mh[0]);
    chk({tag, "_h2"},  tap(1), mh[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(0, 1'b0, 1'b0); cyc(0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int       x;
    bit       v;
    bit [1:0] sym;
    int       eq;
    int       err;
    bit       ov;
  } vec_t;
  vec_t vecs[13];

  int xs[NSYM], tl[NSYM];
  int taps_ref0, taps_ref1;
  logic [30:0] lfsr;

  initial begin
    rst = 1'b1; signal_in = '0; signal_in_valid = 1'b0; adapt_en = 1'b0;
    s_in = '0; s_vld = 1'b0; s_aen = 1'b0;
    vecs[0]  = '{44,  1, 2'b00, 44,  0,   1};
    vecs[1]  = '{100, 1, 2'b01, 100, 0,   1};
    vecs[2]  = '{156, 1, 2'b11, 156, 0,   1};
    vecs[3]  = '{212, 1, 2'b10, 212, 0,   1};
    vecs[4]  = '{0,   0, 2'b10, 212, 0,   0};
    vecs[5]  = '{71,  1, 2'b00, 71,  27,  1};
    vecs[6]  = '{72,  1, 2'b01, 72,  -28, 1};
    vecs[7]  = '{127, 1, 2'b01, 127, 27,  1};
    vecs[8]  = '{128, 1, 2'b11, 128, -28, 1};
    vecs[9]  = '{183, 1, 2'b11, 183, 27,  1};
    vecs[10] = '{184, 1, 2'b10, 184, -28, 1};
    vecs[11] = '{255, 1, 2'b10, 255, 43,  1};
    vecs[12] = '{0,   1, 2'b00, 0,   -44, 1};

    // Reset state.
    cyc(0, 1'b1, 1'b0); cyc(0, 1'b1, 1'b0);
    chk("rst_vld", int'(symbol_out_valid), 0);
    chk("rst_sym", int'(symbol_out), 0);
    chk("rst_eq", int'(equalized_out), 0);
    chk("rst_err", int'(error_out), 0);
    chk("rst_taps", int'(taps_out), 0);
    rst = 1'b0;

    // Directed vectors, no adaptation.
    foreach (vecs[i]) begin
      cyc(vecs[i].x, vecs[i].v, 1'b0);
      chk($sformatf("vec%0d_sym", i), int'(symbol_out), int'(vecs[i].sym));
      chk($sformatf("vec%0d_vld", i), int'(symbol_out_valid), int'(vecs[i].ov));
      chk($sformatf("vec%0d_eq", i), int'(equalized_out), vecs[i].eq);
      chk($sformatf("vec%0d_err", i), int'($signed(error_out)), vecs[i].err);
      chk($sformatf("vec%0d_taps", i), int'(taps_out), 0);
    end

    // Build a PRBS31 symbol stream through a channel with +14 post-cursor.
    lfsr = 31'h7fffffff;
    for (int n = 0; n < NSYM; n++) begin
      int l, v;
      l = 0;
      for (int b = 0; b < 2; b++) begin
        lfsr = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
        l = (l << 1) | int'(lfsr[0]);
      end
      tl[n] = l;
      v = LV[l] + ((n > 0) ? 14 * DV[tl[n-1]] : 0);
      xs[n] = (v < 0) ? 0 : (v > 255) ? 255 : v;
    end

    // Gap-free adaptation run.
    do_reset();
    for (int n = 0; n < NSYM; n++) begin
      sample_chk("adapt", xs[n], 1'b1);
      if (n >= NSYM - 1000) chk("adapt_tx_sym", int'(symbol_out), gray(tl[n]));
    end
    chk("adapt_h1_conv", int'(tap(0) >= 13 && tap(0) <= 15), 1);
    chk("adapt_h2_conv", int'(tap(1) >= -2 && tap(1) <= 2), 1);
    taps_ref0 = mh[0]; taps_ref1 = mh[1];

    // Reset in the middle of a valid burst.
    for (int n = 0; n < 5; n++) sample_chk("burst", xs[n], 1'b1);
    rst = 1'b1;
    cyc(xs[5], 1'b1, 1'b1);
    rst = 1'b0;
    model_reset();
    chk("midrst_vld", int'(symbol_out_valid), 0);
    chk("midrst_sym", int'(symbol_out), 0);
    chk("midrst_eq", int'(equalized_out), 0);
    chk("midrst_err", int'(error_out), 0);
    chk("midrst_taps", int'(taps_out), 0);
    for (int n = 6; n < 60; n++) sample_chk("resume", xs[n], 1'b1);

    // Same stream with random idle gaps; outputs hold, taps frozen in gaps.
    do_reset();
    for (int n = 0; n < NSYM; n++) begin
      int g;
      g = $urandom_range(0, 5);
      for (int i = 0; i < g; i++) begin
        cyc(8'hA5, 1'b0, 1'b1);
        chk("gap_vld", int'(symbol_out_valid), 0);
        chk("gap_hold_sym", int'(symbol_out), ex_sym);
        chk("gap_h1", tap(0), mh[0]);
      end
      sample_chk("gapped", xs[n], 1'b1);
    end
    chk("gap_final_h1", tap(0), taps_ref0);
    chk("gap_final_h2", tap(1), taps_ref1);

    // Adaptation off freezes taps immediately.
    for (int n = 0; n < 20; n++) sample_chk("frozen", xs[n] + 3, 1'b0);
    chk("frozen_h1", tap(0), taps_ref0);

    // Saturation: constant 255 keeps e positive with d=+3 history.
    do_reset();
    s_in = 8'd255; s_vld = 1'b1; s_aen = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      chk("sat_h1_nonneg", int'(s_taps[3]), 0);
      chk("sat_h2_nonneg", int'(s_taps[7]), 0);
      chk("sat_sym", int'(s_sym), 2);
    end
    chk("sat_h1", int'($signed(s_taps[3:0])), 7);
    chk("sat_h2", int'($signed(s_taps[7:4])), 7);
    chk("sat_eq", int'(s_eq), 213);
    chk("sat_err", int'($signed(s_err)), 1);
    s_vld = 1'b0;
    @(negedge clk);
    chk("sat_vld_off", int'(s_ovld), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
